// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcode values, decode FSM encoding, NOP word.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package pipeline_pkg;

    localparam logic [5:0] OP_NOP   = 6'd0;
    localparam logic [5:0] OP_LOAD  = 6'd1;
    localparam logic [5:0] OP_STORE = 6'd2;
    localparam logic [5:0] OP_ALU   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_JMP   = 6'd6;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Opcodes outside the defined set travel down the pipe as NOP.
    function automatic logic [5:0] legal_op(input logic [5:0] op);
        return (op <= OP_JMP) ? op : OP_NOP;
    endfunction

endpackage

// File: rtl/hazard_unit.sv
// Load-use detector: instruction in decode reads the register an in-flight LOAD writes.
// Latency: combinational, 0 cycles.
// Backpressure: none; result feeds the decode stall.
// Ports: ex_op/ex_rd = ID/EX latch contents, rs/rt = decode read addresses, load_use = hazard.
module hazard_unit
    import pipeline_pkg::*;
(
    input  logic [5:0] ex_op,
    input  logic [4:0] ex_rd,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    output logic       load_use
);

    // Bubbles carry OP_NOP, so op alone tells whether a valid LOAD is in flight.
    // Register 0 is hard-wired and can never be a real dependency.
    assign load_use = (ex_op == OP_LOAD) && (ex_rd != 5'd0) &&
                      ((ex_rd == rs) || (ex_rd == rt));

endmodule

// File: rtl/decode_stage.sv
// Instruction decode with ID/EX latch, load-use stall and branch/jump redirect + squash.
// Latency: 1 cycle instr -> ID/EX latch; stall/dec/pc_target/rs_addr/rt_addr combinational.
// Backpressure: stall holds fetch for one cycle on load-use; dec redirects fetch, then FLUSH_CYCLES squashed.
// Ports: clk, rst (async active-low); instr/pc_in/in_valid from fetch; rs_data/rt_data from regfile;
//        rs_addr/rt_addr to regfile; stall/dec/pc_target to fetch; out_* = registered ID/EX latch.
// Optional: define DECODE_STATS_EN to add redirect_cnt, a saturating 16-bit count of dec pulses.
module decode_stage
    import pipeline_pkg::*;
#(
    parameter int PC_W         = 7,   // must not exceed 16 (target built from imm)
    parameter int FLUSH_CYCLES = 2    // 1..3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr,
    input  logic [PC_W-1:0] pc_in,
    input  logic            in_valid,
    input  logic [31:0]     rs_data,
    input  logic [31:0]     rt_data,
    output logic [4:0]      rs_addr,
    output logic [4:0]      rt_addr,
    output logic            stall,
    output logic            dec,
    output logic [PC_W-1:0] pc_target,
    output logic            out_valid,
    output logic [5:0]      out_op,
    output logic [4:0]      out_rd,
    output logic [31:0]     out_a,
    output logic [31:0]     out_b,
    output logic [15:0]     out_imm,
`ifdef DECODE_STATS_EN
    output logic [15:0]     redirect_cnt,
`endif
    output logic [PC_W-1:0] out_pc
);

    logic [5:0]  op_f;
    logic [4:0]  rd_f;
    logic [15:0] imm_f;

    assign op_f    = instr[31:26];
    assign rs_addr = instr[25:21];
    assign rt_addr = instr[20:16];
    assign rd_f    = instr[15:11];
    assign imm_f   = instr[15:0];

    state_t          state_q, state_d;
    logic [1:0]      flush_cnt_q, flush_cnt_d;
    logic            valid_q, valid_d;
    logic [5:0]      op_q, op_d;
    logic [4:0]      rd_q, rd_d;
    logic [31:0]     a_q, a_d;
    logic [31:0]     b_q, b_d;
    logic [15:0]     imm_q, imm_d;
    logic [PC_W-1:0] pc_q, pc_d;

    logic load_use;
    logic take_c;
    logic hold_c;

    hazard_unit u_hazard (
        .ex_op    (op_q),
        .ex_rd    (rd_q),
        .rs       (rs_addr),
        .rt       (rt_addr),
        .load_use (load_use)
    );

    // Target arithmetic wraps naturally at PC_W bits.
    logic [PC_W-1:0] jmp_tgt;
    logic [PC_W-1:0] br_tgt;
    assign jmp_tgt   = instr[PC_W-1:0];
    assign br_tgt    = pc_in + PC_W'(1) + imm_f[PC_W-1:0];
    assign pc_target = (op_f == OP_JMP) ? jmp_tgt : br_tgt;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        take_c      = 1'b0;
        hold_c      = 1'b0;
        // Default latch load is a bubble.
        valid_d     = 1'b0;
        op_d        = OP_NOP;
        rd_d        = 5'd0;
        a_d         = 32'd0;
        b_d         = 32'd0;
        imm_d       = 16'd0;
        pc_d        = '0;

        case (state_q)
            // STALL is the single reissue cycle after a load-use bubble: the held
            // instruction decodes exactly as in RUN, and the LOAD has already left
            // ID/EX so it cannot stall again. A stalled branch resolves here.
            ST_RUN, ST_STALL: begin
                if (!in_valid) begin
                    state_d = ST_RUN;
                end else if ((state_q == ST_RUN) && load_use) begin
                    hold_c  = 1'b1;
                    state_d = ST_STALL;
                end else begin
                    valid_d = 1'b1;
                    op_d    = legal_op(op_f);
                    rd_d    = rd_f;
                    a_d     = rs_data;
                    b_d     = rt_data;
                    imm_d   = imm_f;
                    pc_d    = pc_in;
                    take_c  = (op_f == OP_JMP) ||
                              ((op_f == OP_BEQ) && (rs_data == rt_data)) ||
                              ((op_f == OP_BNE) && (rs_data != rt_data));
                    state_d     = take_c ? ST_FLUSH : ST_RUN;
                    flush_cnt_d = 2'd0;
                end
            end
            // Wrong-path slots are squashed whether or not fetch marked them valid.
            ST_FLUSH: begin
                if (flush_cnt_q == 2'(FLUSH_CYCLES - 1)) begin
                    state_d     = ST_RUN;
                    flush_cnt_d = 2'd0;
                end else begin
                    flush_cnt_d = flush_cnt_q + 2'd1;
                end
            end
            default: begin
                state_d     = ST_RUN;
                flush_cnt_d = 2'd0;
            end
        endcase
    end

    // Strobes are forced low while reset is held so fetch never sees a redirect or hold.
    assign dec   = take_c & rst;
    assign stall = hold_c & rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= 2'd0;
            valid_q     <= 1'b0;
            op_q        <= OP_NOP;
            rd_q        <= 5'd0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            imm_q       <= 16'd0;
            pc_q        <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            valid_q     <= valid_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            a_q         <= a_d;
            b_q         <= b_d;
            imm_q       <= imm_d;
            pc_q        <= pc_d;
        end
    end

    assign out_valid = valid_q;
    assign out_op    = op_q;
    assign out_rd    = rd_q;
    assign out_a     = a_q;
    assign out_b     = b_q;
    assign out_imm   = imm_q;
    assign out_pc    = pc_q;

`ifdef DECODE_STATS_EN
    logic [15:0] redirect_cnt_q, redirect_cnt_d;

    always_comb begin
        redirect_cnt_d = redirect_cnt_q;
        if (dec && (redirect_cnt_q != 16'hFFFF)) begin
            redirect_cnt_d = redirect_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            redirect_cnt_q <= 16'd0;
        end else begin
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign redirect_cnt = redirect_cnt_q;
`endif

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter PC_W, default 7, instruction address width.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, wrong-path fetches squashed after a redirect (range 1..3).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 instr  input  32  instruction word from fetch memory output.
REQ-006 pc_in  input  PC_W  address of instr.
REQ-007 in_valid  input  1  instr/pc_in valid this cycle (fetch not bubbling).
REQ-008 rs_data, rt_data  input  32 each  register-file read data for rs_addr/rt_addr.
REQ-009 rs_addr, rt_addr  output  5 each  combinational register read addresses, instr[25:21] / instr[20:16].
REQ-010 stall  output  1  holds fetch PC (drives fetch enable low).
REQ-011 dec  output  1  one-cycle redirect strobe to fetch PC mux.
REQ-012 pc_target  output  PC_W  redirect address, valid while dec=1.
REQ-013 out_valid, out_op(6), out_rd(5), out_a(32), out_b(32), out_imm(16), out_pc(PC_W)  output  registered ID/EX latch.

Function
REQ-014 SHALL decode op=instr[31:26], rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0].
REQ-015 SHALL implement FSM states RUN, STALL, FLUSH; reset state RUN.
REQ-016 RUN: accepted instruction (in_valid=1, not squashed) SHALL register into ID/EX latch next edge with out_valid=1; latency 1 cycle.
REQ-017 JMP SHALL assert dec for one cycle, pc_target=instr[PC_W-1:0], then go to FLUSH; JMP itself forwarded with out_valid=1.
REQ-018 BEQ/BNE SHALL compare rs_data with rt_data; if taken, dec=1, pc_target=(pc_in+1+imm[PC_W-1:0]) mod 2^PC_W (wrap-around), then FLUSH; not taken stays RUN.
REQ-019 FLUSH SHALL count FLUSH_CYCLES cycles; ID/EX latch loads out_valid=0 and out_op=NOP; return to RUN on count expiry; in_valid=0 cycles still count.
REQ-020 Load-use: if ID/EX holds valid LOAD and out_rd matches current rs or rt (nonzero), SHALL assert stall, hold instr, insert bubble (out_valid=0), go STALL for exactly 1 cycle, then reissue in RUN.
REQ-021 Branch whose operands hit load-use SHALL stall first; dec only after reissue.
REQ-022 dec and stall SHALL never be 1 in the same cycle; redirect during STALL is impossible by REQ-021.
REQ-023 in_valid=0 in RUN SHALL load a bubble (out_valid=0).
REQ-024 Register 0 SHALL never trigger load-use.
REQ-025 Undefined opcodes SHALL pass as NOP with out_valid=1.

Reset
REQ-026 rst=0 SHALL immediately force: state RUN, flush counter 0, out_valid=0, out_op=NOP, out_rd/out_a/out_b/out_imm/out_pc=0, dec=0, stall=0.
REQ-027 Reset mid-FLUSH or mid-STALL SHALL abort it; first valid instruction after release decodes normally.

Configuration
REQ-028 Macro DECODE_STATS_EN: when defined, SHALL add output redirect_cnt(16), saturating count of dec pulses, reset 0; when undefined, port and counter SHALL be absent and behaviour otherwise identical.

Structure
REQ-029 Opcode constants (NOP=0, LOAD, STORE, ALU, BEQ, BNE, JMP), FSM state encoding and NOP word SHALL live in shared package pipeline_pkg.
REQ-030 Hazard comparison SHALL be sub-module hazard_unit (combinational, inputs ID/EX op/rd, rs, rt; output load_use).

Verification
REQ-031 Reset: rst=0 mid-stream -> all outputs 0 same cycle, out_op=NOP.
REQ-032 JMP pc_in=5, target=0x40 -> dec=1 one cycle, pc_target=0x40, next 2 latched entries out_valid=0, then RUN.
REQ-033 BEQ pc_in=0x7E, imm=3, rs_data=rt_data=9 -> pc_target=0x02 (wrap); rs_data=9, rt_data=8 -> no dec, out_valid continuous.
REQ-034 LOAD rd=4 then ALU rs=4 -> stall=1 one cycle, one bubble, ALU issued next cycle; ALU rs=0 after LOAD rd=0 -> no stall.
REQ-035 LOAD rd=3 then BNE rt=3 taken -> stall cycle, then dec on reissue, then FLUSH.
REQ-036 With DECODE_STATS_EN, 70000 taken branches -> redirect_cnt=0xFFFF saturated.
